// File: rtl/led_display_arbiter.sv
// led_display_arbiter
// Round-robin arbiter sharing one three-digit seven-segment driver between two
// requesters. A grant is held for at least DWELL cycles while the other side
// is waiting, the owners alternate under contention, and the owner may release
// early at any time.
//
// Ports
//   clock, reset_n      : clock, synchronous active-low reset
//   req0/data0          : requester 0 request and 12-bit digits {x2,x1,x0}
//   req1/data1          : requester 1 request and digits
//   gnt0/gnt1           : registered grants (one-hot or both low)
//   x0/x1/x2            : registered digit values to LED_driver
//   blank               : registered, high while nobody owns the display
module led_display_arbiter #(
  parameter int          DWELL    = 16,
  parameter logic [11:0] IDLE_VAL = 12'h000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0,
  input  logic [11:0] data0,
  input  logic        req1,
  input  logic [11:0] data1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [3:0]  x0,
  output logic [3:0]  x1,
  output logic [3:0]  x2,
  output logic        blank
);

  localparam int            CW   = $clog2(DWELL) + 1;
  localparam logic [CW-1:0] CMAX = CW'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, G0, G1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;   // 1 = requester 1 granted most recently
  logic [11:0]   disp_q, disp_d;

  // Helper signals for the shared G0/G1 decision and the common grant action.
  logic owner, req_own, req_oth, grant, who;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    disp_d  = disp_q;
    owner   = (state_q == G1);
    req_own = owner ? req1 : req0;
    req_oth = owner ? req0 : req1;
    grant   = 1'b0;
    who     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // On a tie the side that did not own the display last wins.
        if (req0 && req1) begin
          grant = 1'b1;
          who   = ~last_q;
        end else if (req0) begin
          grant = 1'b1;
          who   = 1'b0;
        end else if (req1) begin
          grant = 1'b1;
          who   = 1'b1;
        end
      end
      G0, G1: begin
        if (!req_own) begin
          if (req_oth) begin
            grant = 1'b1;
            who   = ~owner;
          end else begin
            state_d = IDLE;
            disp_d  = IDLE_VAL;
          end
        end else if (cnt_q < CMAX) begin
          cnt_d  = cnt_q + CW'(1);
          disp_d = owner ? data1 : data0;
        end else if (req_oth) begin
          grant = 1'b1;
          who   = ~owner;
        end else begin
          // Dwell expired but uncontested: keep the display, cnt stays
          // saturated so a later request switches on its first edge.
          disp_d = owner ? data1 : data0;
        end
      end
      default: begin
        state_d = IDLE;
        disp_d  = IDLE_VAL;
      end
    endcase
    if (grant) begin
      state_d = who ? G1 : G0;
      cnt_d   = '0;
      last_d  = who;
      disp_d  = who ? data1 : data0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      disp_q  <= IDLE_VAL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      disp_q  <= disp_d;
    end
  end

  assign gnt0  = (state_q == G0);
  assign gnt1  = (state_q == G1);
  assign blank = (state_q == IDLE);
  assign x0    = disp_q[3:0];
  assign x1    = disp_q[7:4];
  assign x2    = disp_q[11:8];

endmodule

// File: tb/tb_led_display_arbiter.sv
module tb_led_display_arbiter;

  logic        clock = 1'b0;
  logic        reset_n, req0, req1;
  logic [11:0] data0, data1;
  logic        a_gnt0, a_gnt1, a_blank, b_gnt0, b_gnt1, b_blank;
  logic [3:0]  a_x0, a_x1, a_x2, b_x0, b_x1, b_x2;

  int nchk = 0;
  int nerr = 0;

  always #5 clock = ~clock;

  led_display_arbiter #(.DWELL(4), .IDLE_VAL(12'h000)) dut_a (
    .clock(clock), .reset_n(reset_n), .req0(req0), .data0(data0),
    .req1(req1), .data1(data1), .gnt0(a_gnt0), .gnt1(a_gnt1),
    .x0(a_x0), .x1(a_x1), .x2(a_x2), .blank(a_blank));

  led_display_arbiter #(.DWELL(1), .IDLE_VAL(12'h000)) dut_b (
    .clock(clock), .reset_n(reset_n), .req0(req0), .data0(data0),
    .req1(req1), .data1(data1), .gnt0(b_gnt0), .gnt1(b_gnt1),
    .x0(b_x0), .x1(b_x1), .x2(b_x2), .blank(b_blank));

  wire [14:0] act_a = {a_gnt0, a_gnt1, a_blank, a_x2, a_x1, a_x0};
  wire [14:0] act_b = {b_gnt0, b_gnt1, b_blank, b_x2, b_x1, b_x0};

  // Reference model: owner (-1 = nobody), edges held since the grant,
  // last owner and the digits on display.
  int          m_own[2], m_age[2], m_last[2];
  logic [11:0] m_disp[2];
  int          m_dw[2] = '{4, 1};

  function automatic logic [14:0] mexp(int k);
    return {m_own[k] == 0, m_own[k] == 1, m_own[k] < 0, m_disp[k]};
  endfunction

  task automatic mgrant(int k, int n);
    m_own[k]  = n;
    m_age[k]  = 0;
    m_last[k] = n;
    m_disp[k] = (n == 1) ? data1 : data0;
  endtask

  task automatic mstep(int k);
    bit r[2];
    int o;
    r[0] = req0;
    r[1] = req1;
    if (!reset_n) begin
      m_own[k] = -1; m_age[k] = 0; m_last[k] = 1; m_disp[k] = 12'h000;
    end else if (m_own[k] < 0) begin
      if (r[0] && r[1]) mgrant(k, 1 - m_last[k]);
      else if (r[0])    mgrant(k, 0);
      else if (r[1])    mgrant(k, 1);
    end else begin
      o = m_own[k];
      if (!r[o]) begin
        if (r[1-o]) mgrant(k, 1 - o);
        else begin m_own[k] = -1; m_disp[k] = 12'h000; end
      end else if (m_age[k] + 1 >= m_dw[k] && r[1-o]) begin
        mgrant(k, 1 - o);
      end else begin
        m_age[k]++;
        m_disp[k] = (o == 1) ? data1 : data0;
      end
    end
  endtask

  task automatic check(string name, logic [14:0] act, logic [14:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got g0g1b=%b x=%h, expected g0g1b=%b x=%h",
               name, act[14:12], act[11:0], exp[14:12], exp[11:0]);
    end
  endtask

  // One clock edge; the DWELL=1 instance is checked against the model on
  // every edge, the DWELL=4 instance by the caller.
  task automatic tick();
    @(posedge clock);
    #1;
    mstep(0);
    mstep(1);
    check("dwell1_model", act_b, mexp(1));
  endtask

  task automatic drive(bit rst, bit r0, bit r1, logic [11:0] d0, logic [11:0] d1);
    reset_n = ~rst; req0 = r0; req1 = r1; data0 = d0; data1 = d1;
  endtask

  typedef struct {
    bit          rst, r0, r1;
    logic [11:0] d0, d1;
    logic [14:0] exp;
  } vec_t;

  function automatic vec_t mk(bit rst, bit r0, bit r1, logic [2:0] g, logic [11:0] x);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.d0 = 12'h108; v.d1 = 12'h2A5;
    v.exp = {g, x};
    return v;
  endfunction

  localparam logic [2:0] GI = 3'b001, GA = 3'b100, GB = 3'b010;

  initial begin
    vec_t tbl[$];
    drive(1, 0, 0, 12'h108, 12'h2A5);
    // reset, tie to requester 0, DWELL=4 alternation, early hand-off, release
    tbl.push_back(mk(1, 0, 0, GI, 12'h000));
    tbl.push_back(mk(1, 1, 1, GI, 12'h000));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 1, GA, 12'h108));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 1, GB, 12'h2A5));
    tbl.push_back(mk(0, 1, 1, GA, 12'h108));
    tbl.push_back(mk(0, 0, 1, GB, 12'h2A5));
    tbl.push_back(mk(0, 0, 0, GI, 12'h000));
    tbl.push_back(mk(0, 0, 0, GI, 12'h000));
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].r0, tbl[i].r1, tbl[i].d0, tbl[i].d1);
      tick();
      check($sformatf("vec%0d", i), act_a, tbl[i].exp);
    end

    // Uncontested hold for 20 cycles, then a late requester switches at once.
    drive(0, 0, 1, 12'h108, 12'h2A5);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_g1", act_a, {GB, 12'h2A5});
    end
    req0 = 1'b1;
    tick();
    check("late_req0", act_a, {GA, 12'h108});

    // Early release with nobody waiting, then with requester 1 waiting.
    req1 = 1'b0;
    tick();
    tick();
    check("g0_held", act_a, {GA, 12'h108});
    req0 = 1'b0;
    tick();
    check("release_idle", act_a, {GI, 12'h000});
    req0 = 1'b1;
    tick();
    check("regrant_g0", act_a, {GA, 12'h108});
    tick();
    req0 = 1'b0; req1 = 1'b1;
    tick();
    check("release_to_g1", act_a, {GB, 12'h2A5});

    // Live data update from the owner, then a reset mid-grant.
    data1 = 12'h3F0;
    tick();
    check("live_data", act_a, {GB, 12'h3F0});
    data0 = 12'h5C7;
    tick();
    check("nonowner_ignored", act_a, {GB, 12'h3F0});
    reset_n = 1'b0;
    tick();
    check("mid_reset", act_a, {GI, 12'h000});
    reset_n = 1'b1; req0 = 1'b1;
    tick();
    check("tie_after_reset", act_a, {GA, 12'h5C7});

    // Randomised traffic against the reference model for both instances.
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      req0    = ($urandom_range(0, 3) != 0);
      req1    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) data0 = 12'($urandom);
      if ($urandom_range(0, 3) == 0) data1 = 12'($urandom);
      tick();
      check("rand_dwell4", act_a, mexp(0));
      if (a_gnt0 && a_gnt1) check("gnt_exclusive", act_a, mexp(0) & 15'h3FFF);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
